gradients_frame_ctrl: RTL



---
 rtl/gradients_pkg.sv | 14 +
 rtl/gradients_frame_ctrl_valid_delay_line.sv | 25 ++
 rtl/gradients_frame_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gradients_pkg.sv
// Shared encodings and window geometry for the 5x5 gradient frame sequencer.
package gradients_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WIN_RADIUS = 2;
    localparam int WIN_SIZE   = 5;

endpackage

// File: rtl/gradients_frame_ctrl_valid_delay_line.sv
// Fixed-depth shift register used to align side-band data with the gradient pipeline.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/gradients_frame_ctrl.sv
// Frame sequencer: counts the pixel stream, qualifies interior windows and
// tracks them through the fixed datapath latency to an aligned out_valid.
module gradients_frame_ctrl
    import gradients_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int LATENCY = 6,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          win_valid,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overrun
);

    localparam int FW = $clog2(LATENCY + 1);
    localparam int DW = 1 + 2 * CW;

    state_t        state, state_nxt;
    logic [CW-1:0] row, col;
    logic [CW-1:0] hold_row, hold_col;
    logic [CW-1:0] ctr_row, ctr_col;
    logic [FW-1:0] flush_cnt;
    logic          cnt_clr, cnt_adv, flush_load, last_pix;
    logic [DW-1:0] dl_in, dl_tap;

    assign last_pix  = (row == CW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign win_valid = in_valid && (state == RUN) &&
                       (row >= CW'(WIN_SIZE - 1)) && (col >= CW'(WIN_SIZE - 1));
    assign ctr_row   = row - CW'(WIN_RADIUS);
    assign ctr_col   = col - CW'(WIN_RADIUS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_adv    = 1'b0;
        flush_load = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (in_valid) begin
                    cnt_adv = 1'b1;
                    if (last_pix) begin
                        state_nxt  = FLUSH;
                        flush_load = 1'b1;
                    end
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_cnt == FW'(1)) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            flush_cnt   <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (cnt_clr) begin
                row <= '0;
                col <= '0;
            end else if (cnt_adv) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (flush_load)          flush_cnt <= FW'(LATENCY);
            else if (state == FLUSH) flush_cnt <= flush_cnt - FW'(1);
            if (in_valid && (state == IDLE || state == FLUSH)) err_overrun <= 1'b1;
        end
    end

    // Non-qualified slots carry the most recent centre so the tap holds
    // its coordinates while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_row <= '0;
            hold_col <= '0;
        end else if (win_valid) begin
            hold_row <= ctr_row;
            hold_col <= ctr_col;
        end
    end

    assign dl_in = {win_valid,
                    win_valid ? ctr_row : hold_row,
                    win_valid ? ctr_col : hold_col};

    valid_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (DW)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .d   (dl_in),
        .q   (dl_tap)
    );

    assign out_valid = dl_tap[DW-1];
    assign out_row   = dl_tap[2*CW-1:CW];
    assign out_col   = dl_tap[CW-1:0];

endmodule
